// File: rtl/adder4_pkg.sv
// Shared width, operand type and result bundle for the registered 4-bit adder.
package adder4_pkg;

    localparam int ADDER4_W = 4;

    typedef logic [ADDER4_W-1:0] nib_t;

    typedef struct packed {
        nib_t s;
        logic cf;
        logic of;
        logic zf;
    } adder4_res_t;

endpackage

// File: rtl/adder4_full_adder.sv
// Single-bit full adder, one stage of the adder4 ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder4.sv
// Registered 4-bit ripple-carry adder with carry, overflow and zero flags.
// Define ADDER4_SUB_EN to add the sub port and build the adder/subtractor.
module adder4
    import adder4_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [ADDER4_W-1:0] a,
    input  logic [ADDER4_W-1:0] b,
    input  logic                cin,
`ifdef ADDER4_SUB_EN
    input  logic                sub,
`endif
    output logic [ADDER4_W-1:0] s,
    output logic                cf,
    output logic                of,
    output logic                zf,
    output logic                out_valid
);

    nib_t              b_eff;
    logic              c0_eff;
    logic [ADDER4_W:0] carry;
    nib_t              sum_next;
    adder4_res_t       res_next;
    adder4_res_t       res_reg;
    logic              valid_reg;

`ifdef ADDER4_SUB_EN
    // Subtract is a + ~b + ~cin; the carry-out is inverted afterwards to read as a borrow.
    assign b_eff  = b ^ {ADDER4_W{sub}};
    assign c0_eff = cin ^ sub;
`else
    assign b_eff  = b;
    assign c0_eff = cin;
`endif

    assign carry[0] = c0_eff;

    generate
        for (genvar gi = 0; gi < ADDER4_W; gi++) begin : g_stage
            full_adder u_fa (
                .a  (a[gi]),
                .b  (b_eff[gi]),
                .ci (carry[gi]),
                .s  (sum_next[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        res_next.s  = sum_next;
`ifdef ADDER4_SUB_EN
        res_next.cf = carry[ADDER4_W] ^ sub;
`else
        res_next.cf = carry[ADDER4_W];
`endif
        // Overflow uses the raw ripple carries, never the borrow-inverted one.
        res_next.of = carry[ADDER4_W-1] ^ carry[ADDER4_W];
        res_next.zf = (sum_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            res_reg   <= res_next;
            valid_reg <= in_valid;
        end
    end

    assign s         = res_reg.s;
    assign cf        = res_reg.cf;
    assign of        = res_reg.of;
    assign zf        = res_reg.zf;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_adder4.sv
// Scoreboard bench for adder4: stimulus pushes arithmetic expectations, a monitor pops and compares.
module tb_adder4;

    typedef struct {
        logic       v;
        int         a;
        int         b;
        int         cin;
        int         sub;
        logic [3:0] s;
        logic       cf;
        logic       of;
        logic       zf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;
    logic [3:0] s;
    logic       cf;
    logic       of;
    logic       zf;
    logic       out_valid;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

`ifdef ADDER4_SUB_EN
    localparam bit SUB_ON = 1'b1;
`else
    localparam bit SUB_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    adder4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER4_SUB_EN
        .sub       (sub),
`endif
        .s         (s),
        .cf        (cf),
        .of        (of),
        .zf        (zf),
        .out_valid (out_valid)
    );

    // Reference: exact integer arithmetic, unsigned for s/cf, signed range test for of.
    function automatic exp_t model(logic v, int ai, int bi, int ci, int si);
        exp_t e;
        int   r;
        int   sr;
        int   sa;
        int   sbv;
        sa  = (ai >= 8) ? ai - 16 : ai;
        sbv = (bi >= 8) ? bi - 16 : bi;
        if (si != 0) begin
            r    = ai - bi - ci;
            sr   = sa - sbv - ci;
            e.cf = (r < 0);
        end else begin
            r    = ai + bi + ci;
            sr   = sa + sbv + ci;
            e.cf = (r > 15);
        end
        e.v   = v;
        e.a   = ai;
        e.b   = bi;
        e.cin = ci;
        e.sub = si;
        e.s   = 4'((r % 16 + 16) % 16);
        e.of  = (sr > 7) || (sr < -8);
        e.zf  = (e.s == 4'd0);
        return e;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(logic v, int ai, int bi, int ci, int si);
        int sub_eff;
        sub_eff = SUB_ON ? si : 0;
        @(negedge clk);
        in_valid = v;
        a        = 4'(ai);
        b        = 4'(bi);
        cin      = ci[0];
        sub      = sub_eff[0];
        sb.push_back(model(v, ai, bi, ci, sub_eff));
    endtask

    // Monitor: every cycle the DUT presents a result, pop and compare all fields.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("txn v=%0d a=%0d b=%0d cin=%0d sub=%0d -> s=%0d cf=%0d of=%0d zf=%0d ov=%0d",
                         e.v, e.a, e.b, e.cin, e.sub, s, cf, of, zf, out_valid);
                check("out_valid", int'(out_valid), int'(e.v));
                check("s", int'(s), int'(e.s));
                check("cf", int'(cf), int'(e.cf));
                check("of", int'(of), int'(e.of));
                check("zf", int'(zf), int'(e.zf));
            end
        end
    end

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b1;
        a        = 4'b1111;
        b        = 4'b1111;
        cin      = 1'b1;
        sub      = 1'b0;

        // Asynchronous reset before the first clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_s", int'(s), 0);
        check("rst_cf", int'(cf), 0);
        check("rst_of", int'(of), 0);
        check("rst_zf", int'(zf), 0);
        check("rst_out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        check("rst_hold_zf", int'(zf), 0);
        check("rst_hold_out_valid", int'(out_valid), 0);

        // Release mid-stream: the first edge captures the inputs already present.
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(model(1'b1, 15, 15, 1, 0));

        drive(1, 1, 3, 1, 0);
        drive(1, 8, 10, 0, 0);
        drive(1, 3, 6, 0, 0);
        drive(1, 7, 0, 1, 0);
        drive(1, 15, 0, 1, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 15, 15, 0, 0);
        drive(1, 8, 8, 0, 0);
`ifdef ADDER4_SUB_EN
        drive(1, 5, 3, 0, 1);
        drive(1, 3, 5, 1, 1);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 1);
        drive(1, 8, 1, 0, 1);
        drive(1, 7, 15, 0, 1);
`endif
        drive(1, 2, 3, 0, 0);
        drive(0, 4, 5, 1, 0);
        drive(1, 6, 9, 1, 0);

        for (int i = 0; i < 60; i++) begin
            drive(logic'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #2;
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
